// File: rtl/axis_bram_cmd_sched.sv
// Command scheduler for axis_bram: queues read descriptors, issues them one at a time and
// tracks each to its tlast beat. Optional stall watchdog: define AXIS_BRAM_SCHED_TIMEOUT_EN.
module axis_bram_cmd_sched #(
  parameter int unsigned C_AXIS_BRAM_ADDR_WIDTH = 12,
  parameter int unsigned C_CMD_FIFO_DEPTH       = 4,
  parameter int unsigned C_TIMEOUT_CYCLES       = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] cmd_r_start_index,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] cmd_r_length,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] cmd_w_start_index,
  output logic                              ctrl_axis_m_start,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_r_start_index,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_r_length,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_w_start_index,
  input  logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(C_CMD_FIFO_DEPTH):0] queue_level,
  output logic                              err_len,
  output logic                              err_timeout
);

  localparam int unsigned AW    = C_AXIS_BRAM_ADDR_WIDTH;
  localparam int unsigned DEPTH = C_CMD_FIFO_DEPTH;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned LW    = PW + 1;
  localparam int unsigned BW    = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (C_TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("axis_bram_cmd_sched: unsupported parameter set");
  end

  typedef struct packed {
    logic [AW-1:0] w_start;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_start;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RETIRE = 3'd4
  } state_t;

  state_t        r_state, w_next;
  desc_t         r_mem [DEPTH];
  desc_t         w_head;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          r_cmd_ready, r_busy, r_start, r_done, r_err_len, r_drain;
  logic [AW-1:0] r_r_start, r_r_len, r_w_start, r_beat;
  logic [BW-1:0] w_beat_p1;
  logic          w_push, w_pop, w_load, w_done_nxt, w_set_err_len, w_hs;

`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_stall;
  logic          w_stall_hit, w_set_err_to, r_err_to;
`endif

  assign w_hs        = m_axis_tvalid && m_axis_tready;
  assign w_push      = cmd_valid && r_cmd_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  // Widened so a saturated counter never aliases onto a legal length.
  assign w_beat_p1   = BW'(r_beat) + BW'(1);

`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
  assign w_stall_hit = !w_hs && (r_stall == TW'(C_TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_done_nxt    = 1'b0;
    w_set_err_len = 1'b0;
`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
    w_set_err_to  = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_pop = 1'b1;
          // Zero-length descriptors retire immediately without touching axis_bram.
          if (w_head.r_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load = 1'b1;
            w_next = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN: begin
        if (w_hs && m_axis_tlast) begin
          w_set_err_len = (w_beat_p1 != BW'(r_r_len));
          w_next        = ST_DRAIN;
        end
`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
        else if (w_stall_hit) begin
          w_set_err_to = 1'b1;
          w_next       = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_done_nxt = 1'b1;
          w_next     = ST_RETIRE;
        end
      end
      ST_RETIRE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{w_start: cmd_w_start_index, r_len: cmd_r_length,
                                     r_start: cmd_r_start_index};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level     <= w_level_nxt;
      r_cmd_ready <= (w_level_nxt < LW'(DEPTH));
      r_busy      <= (w_next != ST_IDLE) || (w_level_nxt != '0);
      r_start     <= (w_next == ST_LAUNCH);
      r_done      <= w_done_nxt;
    end
  end

  // Active descriptor, beat tracking and sticky length error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r_start <= '0;
      r_r_len   <= '0;
      r_w_start <= '0;
      r_beat    <= '0;
      r_drain   <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      if (w_load) begin
        r_r_start <= w_head.r_start;
        r_r_len   <= w_head.r_len;
        r_w_start <= w_head.w_start;
      end
      if (r_state == ST_LAUNCH) r_beat <= '0;
      else if ((r_state == ST_RUN) && w_hs && (r_beat != '1)) r_beat <= r_beat + 1'b1;
      r_drain <= (r_state == ST_DRAIN) && !r_drain;
      if (w_set_err_len) r_err_len <= 1'b1;
    end
  end

`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall  <= '0;
      r_err_to <= 1'b0;
    end else begin
      if ((r_state != ST_RUN) || w_hs) r_stall <= '0;
      else if (!w_stall_hit)           r_stall <= r_stall + 1'b1;
      if (w_set_err_to) r_err_to <= 1'b1;
    end
  end
  assign err_timeout = r_err_to;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready          = r_cmd_ready;
  assign ctrl_axis_m_start  = r_start;
  assign ctrl_r_start_index = r_r_start;
  assign ctrl_r_length      = r_r_len;
  assign ctrl_w_start_index = r_w_start;
  assign busy               = r_busy;
  assign done               = r_done;
  assign queue_level        = r_level;
  assign err_len            = r_err_len;

endmodule

// File: tb/tb_axis_bram_cmd_sched.sv
// Bench for axis_bram_cmd_sched: descriptor queue model plus timing rules (start one cycle after
// a pop, done three cycles after the last beat, next start five cycles after the last beat).
module tb_axis_bram_cmd_sched;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 3;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_r_start_index, cmd_r_length, cmd_w_start_index;
  logic          ctrl_axis_m_start;
  logic [AW-1:0] ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          busy, done, err_len, err_timeout;
  logic [LW-1:0] queue_level;

  axis_bram_cmd_sched #(
    .C_AXIS_BRAM_ADDR_WIDTH(AW),
    .C_CMD_FIFO_DEPTH      (4),
    .C_TIMEOUT_CYCLES      (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_r_start_index (cmd_r_start_index),
    .cmd_r_length      (cmd_r_length),
    .cmd_w_start_index (cmd_w_start_index),
    .ctrl_axis_m_start (ctrl_axis_m_start),
    .ctrl_r_start_index(ctrl_r_start_index),
    .ctrl_r_length     (ctrl_r_length),
    .ctrl_w_start_index(ctrl_w_start_index),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .busy              (busy),
    .done              (done),
    .queue_level       (queue_level),
    .err_len           (err_len),
    .err_timeout       (err_timeout)
  );

  typedef struct {
    int r;
    int len;
    int w;
    int last_at;
  } desc_t;

  desc_t mq[$];
  int    total = 0;
  int    bad   = 0;
  bit    exp_err = 1'b0;
  int    n_start = 0;
  int    n_done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctrl_axis_m_start) n_start++;
    if (done) n_done++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_start", ctrl_axis_m_start, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", queue_level, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_ctrl", {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index}, 0);
    tick();
    tick();
    reset_n       = 1'b1;
    cmd_valid     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    mq.delete();
    exp_err = 1'b0;
    tick();
    chk("rel_ready", cmd_ready, 1);
    chk("rel_level", queue_level, 0);
    chk("rel_busy", busy, 0);
    chk("rel_start", ctrl_axis_m_start, 0);
  endtask

  task automatic push(input int r, input int len, input int w, input int last_at);
    desc_t d;
    chk("push_ready", cmd_ready, 1);
    cmd_valid         = 1'b1;
    cmd_r_start_index = AW'(r);
    cmd_r_length      = AW'(len);
    cmd_w_start_index = AW'(w);
    tick();
    cmd_valid = 1'b0;
    d.r = r; d.len = len; d.w = w; d.last_at = last_at;
    mq.push_back(d);
  endtask

  task automatic launch(output desc_t d);
    int n;
    d = mq.pop_front();
    n = 0;
    do begin
      tick();
      n++;
    end while (ctrl_axis_m_start !== 1'b1 && n < 20);
    chk("start_latency", n, 1);
    chk("ctrl_load", {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index},
        {AW'(d.r), AW'(d.len), AW'(d.w)});
  endtask

  task automatic stream(input desc_t d, input bit rnd, input bit launch_hs);
    int beat;
    int guard;
    bit fin;
    beat = 0; guard = 0; fin = 1'b0;
    if (launch_hs) begin
      m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b1;
    end
    tick();
    while (!fin && guard < 10000) begin
      m_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tlast  = (beat + 1 == d.last_at);
      tick();
      if (m_axis_tvalid && m_axis_tready) begin
        beat++;
        fin = m_axis_tlast;
      end
      if (!fin) chk("run_no_done", done, 0);
      chk("run_no_start", ctrl_axis_m_start, 0);
      chk("ctrl_stable", {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index},
          {AW'(d.r), AW'(d.len), AW'(d.w)});
      guard++;
    end
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    if (!fin) chk("beat_budget", 0, 1);
    if (d.last_at != d.len) exp_err = 1'b1;
    chk("drain1_done", done, 0);
    tick();
    chk("drain2_done", done, 0);
    tick();
    chk("retire_done", done, 1);
    chk("retire_busy", busy, 1);
    chk("err_len", err_len, exp_err);
    tick();
    chk("post_done", done, 0);
  endtask

  task automatic serve(input bit rnd, input bit launch_hs);
    desc_t d;
    if (mq[0].len == 0) begin
      d = mq.pop_front();
      tick();
      chk("zero_done", done, 1);
      chk("zero_no_start", ctrl_axis_m_start, 0);
    end else begin
      launch(d);
      stream(d, rnd, launch_hs);
    end
  endtask

  initial begin
    desc_t a;
    int    s0, d0, n, len, last;
    reset_n = 1'b0; cmd_valid = 1'b0;
    cmd_r_start_index = '0; cmd_r_length = '0; cmd_w_start_index = '0;
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    tick();
    tick();
    do_reset();

    // Single descriptor, continuous ready.
    push(32'h010, 8, 32'h100, 8);
    chk("t2_level", queue_level, 1);
    chk("t2_busy", busy, 1);
    serve(1'b0, 1'b0);
    chk("t2_idle", busy, 0);

    // One active plus four queued fills the queue.
    push(32'h001, 3, 32'h011, 3);
    launch(a);
    push(32'h002, 2, 32'h012, 2);
    push(32'h003, 5, 32'h013, 5);
    push(32'h004, 1, 32'h014, 1);
    push(32'h005, 4, 32'h015, 4);
    chk("t3_full_ready", cmd_ready, 0);
    chk("t3_full_level", queue_level, 4);
    cmd_valid = 1'b1;
    cmd_r_start_index = 12'hFFF; cmd_r_length = 12'd7; cmd_w_start_index = 12'hEEE;
    repeat (3) begin
      tick();
      chk("t3_blocked_level", queue_level, 4);
    end
    cmd_valid = 1'b0;
    stream(a, 1'b0, 1'b0);
    repeat (4) serve(1'b0, 1'b0);
    chk("t3_idle", busy, 0);

    // Zero-length descriptor between two len=4 descriptors.
    s0 = n_start; d0 = n_done;
    push(32'h020, 4, 32'h030, 4);
    launch(a);
    push(32'h021, 0, 32'h031, 0);
    push(32'h022, 4, 32'h032, 4);
    stream(a, 1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    chk("t4_starts", n_start - s0, 2);
    chk("t4_dones", n_done - d0, 3);

    // Early tlast sets a sticky error; the next descriptor sees a stray launch-cycle beat.
    push(32'h040, 6, 32'h050, 5);
    launch(a);
    push(32'h041, 3, 32'h051, 3);
    stream(a, 1'b0, 1'b0);
    serve(1'b0, 1'b1);
    chk("t5_sticky", err_len, 1);

    // Reset while a transfer is running with work queued.
    push(32'h060, 5, 32'h070, 5);
    launch(a);
    push(32'h061, 5, 32'h071, 5);
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b0;
    repeat (3) tick();
    do_reset();

    // Beat counter saturation: wrap-around would make 8191 beats look like 4095.
    push(32'h0AB, 4095, 32'h0CD, 8191);
    serve(1'b0, 1'b0);
    do_reset();

    // Randomized rounds against the queue model.
    for (int rd = 0; rd < 8; rd++) begin
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        len = int'($urandom_range(1, 12));
        if (k > 0 && $urandom_range(0, 5) == 0) len = 0;
        last = len;
        if (len > 1 && $urandom_range(0, 7) == 0) last = ($urandom_range(0, 1) == 1) ? len + 1 : len - 1;
        push(int'($urandom_range(0, 4095)), len, int'($urandom_range(0, 4095)), last);
        if (k == 0) launch(a);
      end
      chk("rnd_level", queue_level, n - 1);
      stream(a, 1'b1, 1'b0);
      while (mq.size() > 0) serve(1'b1, ($urandom_range(0, 3) == 0));
      chk("rnd_idle", busy, 0);
      chk("rnd_level0", queue_level, 0);
    end

`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
    // Stall watchdog: 16 cycles without a handshake retires the descriptor.
    push(32'h005, 6, 32'h007, 6);
    launch(a);
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    repeat (16) tick();
    chk("to_not_yet", err_timeout, 0);
    tick();
    chk("to_set", err_timeout, 1);
    tick();
    chk("to_drain_done", done, 0);
    tick();
    chk("to_done", done, 1);
    m_axis_tvalid = 1'b0;
    tick();
    chk("to_idle", busy, 0);
    chk("to_sticky", err_timeout, 1);
`else
    // Without the watchdog a long stall just waits.
    push(32'h005, 6, 32'h007, 6);
    launch(a);
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    repeat (40) tick();
    chk("stall_no_to", err_timeout, 0);
    chk("stall_no_done", done, 0);
    chk("stall_busy", busy, 1);
    stream(a, 1'b0, 1'b0);
    chk("stall_err_to", err_timeout, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
